// File: rtl/key_debounce_encoder.sv
// rtl/key_debounce_encoder.sv - button synchroniser, debouncer and press-event serialiser
// Optional build macro: KEY_AUTO_REPEAT_EN (per-button hold auto-repeat).
// Button vectors are ordered {U,L,R}: bit 2 = up, bit 1 = left, bit 0 = right.
module key_debounce_encoder #(
  parameter int DEBOUNCE_MS      = 10,
  parameter int REPEAT_DELAY_MS  = 400,
  parameter int REPEAT_PERIOD_MS = 150
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       one_ms_tick,
  input  logic       btnU,
  input  logic       btnL,
  input  logic       btnR,
  output logic [1:0] key_code,
  output logic       key_valid,
  output logic [2:0] btn_level
);

  // Parameter range checks at elaboration time.
  if (DEBOUNCE_MS < 1 || DEBOUNCE_MS > 15) begin : g_chk_db
    $error("DEBOUNCE_MS out of range 1..15");
  end
  if (REPEAT_DELAY_MS < 1 || REPEAT_DELAY_MS > 1023) begin : g_chk_rd
    $error("REPEAT_DELAY_MS out of range 1..1023");
  end
  if (REPEAT_PERIOD_MS < 1 || REPEAT_PERIOD_MS > 1023) begin : g_chk_rp
    $error("REPEAT_PERIOD_MS out of range 1..1023");
  end

  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_MS - 1);

  logic [2:0] w_raw;
  logic [2:0] r_meta;
  logic [2:0] r_sync;
  logic [2:0] r_level;
  logic [3:0] r_cnt [3];
  logic [2:0] r_pending;
  logic [2:0] w_accept;
  logic [2:0] w_rise;
  logic [2:0] w_set;
  logic [2:0] w_grant;
  logic [1:0] w_code;

  assign w_raw     = {btnU, btnL, btnR};
  assign btn_level = r_level;

  // Two-flop synchroniser for the asynchronous raw buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 3'b000;
      r_sync <= 3'b000;
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
    end
  end

  // A button flips its debounced level on the tick that completes the count.
  always_comb begin
    w_accept = 3'b000;
    for (int i = 0; i < 3; i++) begin
      w_accept[i] = (r_sync[i] != r_level[i]) && one_ms_tick && (r_cnt[i] == DB_LAST);
    end
  end

  assign w_rise = w_accept & r_sync;

  // Per-button debounce counter; any return to the current level restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync[i] == r_level[i]) begin
          r_cnt[i] <= 4'd0;
        end else if (one_ms_tick) begin
          if (w_accept[i]) begin
            r_level[i] <= r_sync[i];
            r_cnt[i]   <= 4'd0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 4'd1;
          end
        end
      end
    end
  end

`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [9:0] REP_LAST   = 10'(REPEAT_DELAY_MS - 1);
  localparam logic [9:0] REP_RELOAD = 10'((REPEAT_DELAY_MS > REPEAT_PERIOD_MS) ?
                                          (REPEAT_DELAY_MS - REPEAT_PERIOD_MS) : 0);

  logic [9:0] r_hold [3];
  logic [2:0] w_repeat;

  // A held button fires a repeat on the tick that would reach the delay.
  always_comb begin
    w_repeat = 3'b000;
    for (int i = 0; i < 3; i++) begin
      w_repeat[i] = r_level[i] && one_ms_tick && (r_hold[i] == REP_LAST);
    end
  end

  // Hold counter: zero while released (which also clears it on the press edge).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        r_hold[i] <= 10'd0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!r_level[i]) begin
          r_hold[i] <= 10'd0;
        end else if (one_ms_tick) begin
          if (w_repeat[i]) begin
            r_hold[i] <= REP_RELOAD;
          end else begin
            r_hold[i] <= r_hold[i] + 10'd1;
          end
        end
      end
    end
  end

  assign w_set = w_rise | w_repeat;
`else
  assign w_set = w_rise;
`endif

  // Fixed-priority pick of one pending event: U, then L, then R.
  always_comb begin
    w_grant = 3'b000;
    w_code  = 2'b00;
    if (r_pending[2]) begin
      w_grant = 3'b100;
      w_code  = 2'b01;
    end else if (r_pending[1]) begin
      w_grant = 3'b010;
      w_code  = 2'b10;
    end else if (r_pending[0]) begin
      w_grant = 3'b001;
      w_code  = 2'b11;
    end
  end

  // Emit one event per cycle; a new set on the same edge overrides the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 3'b000;
      key_code  <= 2'b00;
      key_valid <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_grant) | w_set;
      key_code  <= w_code;
      key_valid <= |r_pending;
    end
  end

endmodule
